// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and state encoding, used by the rotation and vectoring engines.
package cordic_pkg;

  // Angle scale: 131 LSB per degree
  localparam int ANGLE_90  = 11790;
  localparam int ANGLE_180 = 23580;

  // 1/K for the CORDIC gain, Q14
  localparam int GAIN_Q14 = 9949;

  // atan(2^-i) in angle LSBs
  localparam int ATAN_TABLE [16] = '{
    5895, 3480, 1839, 933, 468, 234, 117, 59, 29, 15, 7, 4, 2, 1, 0, 0
  };

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPrescale = 2'd1,
    StRotate   = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_rotate.sv
// Iterative CORDIC in rotation mode: produces magnitude*cos(angle) and magnitude*sin(angle)
// using one micro-rotation per clock after a gain-compensation/quadrant prescale step.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [23:0] crd_angle,
  input  logic signed [23:0] crd_magnitude,
  input  logic               crd_start,
  output logic               crd_busy,
  output logic               crd_done,
  output logic signed [23:0] crd_x,
  output logic signed [23:0] crd_y
);

  // Two guard bits above the 24-bit result cover transient growth during rotation
  localparam int unsigned XW = 26;

  localparam logic signed [23:0] Angle90  = 24'(ANGLE_90);
  localparam logic signed [23:0] Angle180 = 24'(ANGLE_180);

  cordic_state_e        state_q;
  logic [4:0]           iter_q;
  logic signed [XW-1:0] x_q;
  logic signed [XW-1:0] y_q;
  logic signed [23:0]   z_q;

  logic signed [23:0]   angle_clamp;
  logic signed [23:0]   mag_clamp;
  logic signed [40:0]   prescale_prod;
  logic signed [XW-1:0] x0;
  logic signed [XW-1:0] x_shr;
  logic signed [XW-1:0] y_shr;
  logic signed [23:0]   atan_val;

  assign crd_busy = (state_q != StIdle);

  // Input clamping, gain-compensation product and per-iteration shift/atan terms
  always_comb begin
    angle_clamp = crd_angle;
    if (crd_angle > Angle180) begin
      angle_clamp = Angle180;
    end else if (crd_angle < -Angle180) begin
      angle_clamp = -Angle180;
    end
    mag_clamp     = crd_magnitude[23] ? '0 : crd_magnitude;
    // Full-width product so the Q14 scale never overflows before truncation
    prescale_prod = 41'(x_q) * 41'(GAIN_Q14);
    x0            = XW'(prescale_prod >>> 14);
    x_shr         = x_q >>> iter_q;
    y_shr         = y_q >>> iter_q;
    atan_val      = 24'(ATAN_TABLE[iter_q[3:0]]);
  end

  // Control FSM together with the x/y/z datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      iter_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      crd_done <= 1'b0;
      crd_x    <= '0;
      crd_y    <= '0;
    end else begin
      crd_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (crd_start) begin
            // x holds the raw magnitude until prescale scales it
            x_q     <= XW'(mag_clamp);
            y_q     <= '0;
            z_q     <= angle_clamp;
            state_q <= StPrescale;
          end
        end
        StPrescale: begin
          iter_q  <= '0;
          state_q <= StRotate;
          // Fold angles beyond +/-90 deg into convergence range with an exact 90-deg turn
          if (z_q > Angle90) begin
            x_q <= '0;
            y_q <= x0;
            z_q <= z_q - Angle90;
          end else if (z_q < -Angle90) begin
            x_q <= '0;
            y_q <= -x0;
            z_q <= z_q + Angle90;
          end else begin
            x_q <= x0;
            y_q <= '0;
          end
        end
        StRotate: begin
          if (iter_q == 5'(ITERATIONS)) begin
            crd_x    <= x_q[23:0];
            crd_y    <= y_q[23:0];
            crd_done <= 1'b1;
            state_q  <= StIdle;
          end else begin
            if (!z_q[23]) begin
              x_q <= x_q - y_shr;
              y_q <= y_q + x_shr;
              z_q <= z_q - atan_val;
            end else begin
              x_q <= x_q + y_shr;
              y_q <= y_q - x_shr;
              z_q <= z_q + atan_val;
            end
            iter_q <= iter_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotate.sv
// Self-checking bench for cordic_rotate: scoreboard of real-valued cos/sin expectations.
module tb_cordic_rotate;

  localparam int ITER = 14;
  localparam int LAT  = ITER + 2;
  localparam int MAX_WAIT = 100;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [23:0] crd_angle;
  logic signed [23:0] crd_magnitude;
  logic               crd_start;
  logic               crd_busy;
  logic               crd_done;
  logic signed [23:0] crd_x;
  logic signed [23:0] crd_y;

  typedef struct {
    real ex;
    real ey;
    real tol;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cordic_rotate #(.ITERATIONS(ITER)) dut (
    .clk          (clk),
    .rst          (rst),
    .crd_angle    (crd_angle),
    .crd_magnitude(crd_magnitude),
    .crd_start    (crd_start),
    .crd_busy     (crd_busy),
    .crd_done     (crd_done),
    .crd_x        (crd_x),
    .crd_y        (crd_y)
  );

  function automatic exp_t model(int ang, int mag);
    exp_t e;
    real  rad;
    if (ang > 23580) ang = 23580;
    if (ang < -23580) ang = -23580;
    if (mag < 0) mag = 0;
    rad   = real'(ang) * 3.14159265358979 / 23580.0;
    e.ex  = real'(mag) * $cos(rad);
    e.ey  = real'(mag) * $sin(rad);
    e.tol = (mag == 0) ? 0.0 : 0.002 * real'(mag) + 4.0;
    return e;
  endfunction

  function automatic real err(logic signed [23:0] got, real want);
    real d;
    d = real'(int'(got)) - want;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) begin
      e.ex = 1.0e9; e.ey = 1.0e9; e.tol = 0.0;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Start strobe for one edge; optionally waits for the next falling edge first
  task automatic drive_req(input int ang, input int mag, input bit push, input bit align);
    if (align) @(negedge clk);
    crd_angle     = 24'(ang);
    crd_magnitude = 24'(mag);
    crd_start     = 1'b1;
    if (push) sb.push_back(model(ang, mag));
    @(negedge clk);
    crd_start     = 1'b0;
    crd_angle     = 24'($urandom);
    crd_magnitude = 24'($urandom);
  endtask

  // Count falling edges until crd_done, bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!crd_done && n < MAX_WAIT);
  endtask

  task automatic test_reset();
    rst = 1'b1; crd_start = 1'b0; crd_angle = '0; crd_magnitude = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (crd_busy !== 1'b0 || crd_done !== 1'b0 || crd_x !== 24'sd0 || crd_y !== 24'sd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b x=%0d y=%0d, want 0 0 0 0",
               crd_busy, crd_done, crd_x, crd_y);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  localparam int ANGS [7] = '{0, 11790, 23580, -5895, 3930, 30000, -30000};
  localparam int MAGS [7] = '{10000, 10000, 10000, 10000, 32767, 10000, 10000};

  task automatic test_angles();
    int   n;
    exp_t e;
    for (int t = 0; t < 7; t++) begin
      drive_req(ANGS[t], MAGS[t], 1'b1, 1'b1);
      tests++;
      if (crd_busy !== 1'b1) begin
        fails++; $display("FAIL busy_%0d: got %b want 1", t, crd_busy);
      end
      wait_done(n);
      e = pop_exp();
      tests++;
      if (n !== LAT) begin
        fails++; $display("FAIL latency_%0d: got %0d want %0d", t, n, LAT);
      end
      tests++;
      if (err(crd_x, e.ex) > e.tol || err(crd_y, e.ey) > e.tol) begin
        fails++;
        $display("FAIL result_%0d: got x=%0d y=%0d want x=%0.1f y=%0.1f tol %0.1f",
                 t, crd_x, crd_y, e.ex, e.ey, e.tol);
      end
      @(negedge clk);
      tests++;
      if (crd_done !== 1'b0 || crd_busy !== 1'b0) begin
        fails++; $display("FAIL pulse_%0d: done=%b busy=%b want 0 0", t, crd_done, crd_busy);
      end
      // Result must hold while inputs wander with no start
      if (t == 3) begin
        repeat (8) begin
          crd_angle = 24'($urandom); crd_magnitude = 24'($urandom);
          @(negedge clk);
        end
        tests++;
        if (err(crd_x, e.ex) > e.tol || err(crd_y, e.ey) > e.tol || crd_done !== 1'b0) begin
          fails++;
          $display("FAIL hold: got x=%0d y=%0d done=%b want x=%0.1f y=%0.1f done 0",
                   crd_x, crd_y, crd_done, e.ex, e.ey);
        end
      end
    end
  endtask

  task automatic test_zero_mag();
    int   n;
    exp_t e;
    int   m [2] = '{0, -500};
    for (int t = 0; t < 2; t++) begin
      drive_req(5000, m[t], 1'b1, 1'b1);
      wait_done(n);
      e = pop_exp();
      tests++;
      if (n !== LAT || crd_x !== 24'(int'(e.ex)) || crd_y !== 24'(int'(e.ey))) begin
        fails++;
        $display("FAIL zero_mag_%0d: got n=%0d x=%0d y=%0d want n=%0d x=0 y=0",
                 t, n, crd_x, crd_y, LAT);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   n, dones, first;
    logic signed [23:0] fx, fy;
    exp_t e;
    drive_req(-5895, 10000, 1'b1, 1'b1);
    n = 0; dones = 0; first = 0; fx = '0; fy = '0;
    repeat (40) begin
      @(negedge clk);
      n++;
      if (crd_done) begin
        dones++;
        if (first == 0) begin first = n; fx = crd_x; fy = crd_y; end
      end
      // Extra strobes land on edges 3 and 10 of the running operation
      crd_start     = (n == 2 || n == 9);
      crd_angle     = 24'(11790);
      crd_magnitude = 24'(5000);
    end
    crd_start = 1'b0;
    e = pop_exp();
    tests++;
    if (dones !== 1 || first !== LAT) begin
      fails++; $display("FAIL busy_ignore: dones=%0d at %0d, want 1 at %0d", dones, first, LAT);
    end
    tests++;
    if (err(fx, e.ex) > e.tol || err(fy, e.ey) > e.tol) begin
      fails++;
      $display("FAIL busy_result: got x=%0d y=%0d want x=%0.1f y=%0.1f", fx, fy, e.ex, e.ey);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    drive_req(3930, 32767, 1'b1, 1'b1);
    wait_done(n);
    e = pop_exp();
    tests++;
    if (n !== LAT || err(crd_x, e.ex) > e.tol || err(crd_y, e.ey) > e.tol) begin
      fails++; $display("FAIL b2b_first: n=%0d x=%0d y=%0d", n, crd_x, crd_y);
    end
    // Next request on the very first idle edge
    drive_req(-5895, 10000, 1'b1, 1'b0);
    wait_done(n);
    e = pop_exp();
    tests++;
    if (n !== LAT || err(crd_x, e.ex) > e.tol || err(crd_y, e.ey) > e.tol) begin
      fails++;
      $display("FAIL b2b_second: got n=%0d x=%0d y=%0d want n=%0d x=%0.1f y=%0.1f",
               n, crd_x, crd_y, LAT, e.ex, e.ey);
    end
  endtask

  task automatic test_reset_abort();
    int   n, dones;
    exp_t e;
    drive_req(3930, 32767, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (crd_done) dones++;
    end
    tests++;
    if (dones !== 0 || crd_x !== 24'sd0 || crd_y !== 24'sd0 || crd_busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: dones=%0d x=%0d y=%0d busy=%b want 0 0 0 0",
               dones, crd_x, crd_y, crd_busy);
    end
    drive_req(0, 10000, 1'b1, 1'b1);
    wait_done(n);
    e = pop_exp();
    tests++;
    if (n !== LAT || err(crd_x, e.ex) > e.tol || err(crd_y, e.ey) > e.tol) begin
      fails++;
      $display("FAIL after_abort: got n=%0d x=%0d y=%0d want n=%0d x=%0.1f y=%0.1f",
               n, crd_x, crd_y, LAT, e.ex, e.ey);
    end
  endtask

  initial begin
    test_reset();
    test_angles();
    test_zero_mag();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
